// File: rtl/sub_32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sub_32_pkg
//  Description : Shared defaults and elaboration helpers for the segmented
//                pipelined subtractor (sub_32_pipe / sub_seg).
//                - c_DEF_WIDTH / c_DEF_SEG_W : default operand / segment width
//                - nseg_of()                 : number of segments = pipe depth
//                - seg_cfg_ok()              : WIDTH must split evenly into
//                                              SEG_W-bit segments
//  Revision    : 1.0 - initial release
// ============================================================================
package sub_32_pkg;

    localparam int c_DEF_WIDTH = 32;
    localparam int c_DEF_SEG_W = 16;

    // Pipeline depth equals the number of segments.
    function automatic int nseg_of(input int width, input int seg_w);
        return width / seg_w;
    endfunction

    // True when the segment width tiles the operand width exactly.
    function automatic bit seg_cfg_ok(input int width, input int seg_w);
        return (seg_w > 0) && (width >= seg_w) && ((width % seg_w) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sub_seg.sv
`default_nettype none
// ============================================================================
//  Module      : sub_seg
//  Description : One registered segment of the subtractor. Computes
//                i_a + ~i_b + i_cin in SEG_W+1 bits and registers the low
//                SEG_W bits as the difference and the top bit as carry-out
//                (carry = NOT borrow).
//  Ports       : clk, rst     - clock, synchronous active-high reset
//                i_en         - load enable (pipeline advance)
//                i_a, i_b     - SEG_W-bit minuend / subtrahend segment
//                i_cin        - carry in (1 for the least significant segment)
//                o_diff       - registered SEG_W-bit difference
//                o_cout       - registered carry out
//  Revision    : 1.0 - initial release
// ============================================================================
module sub_seg #(
    parameter int SEG_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [SEG_W-1:0] i_a,
    input  logic [SEG_W-1:0] i_b,
    input  logic             i_cin,
    output logic [SEG_W-1:0] o_diff,
    output logic             o_cout
);

    logic [SEG_W:0]   w_sum;
    logic [SEG_W-1:0] r_diff;
    logic             r_cout;

    assign w_sum = {1'b0, i_a} + {1'b0, ~i_b} + {{SEG_W{1'b0}}, i_cin};

    // Carry resets to 1, i.e. "no borrow": the cleared state reads as 0 - 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_diff <= '0;
            r_cout <= 1'b1;
        end else if (i_en) begin
            r_diff <= w_sum[SEG_W-1:0];
            r_cout <= w_sum[SEG_W];
        end
    end

    assign o_diff = r_diff;
    assign o_cout = r_cout;

endmodule
`default_nettype wire

// File: rtl/sub_32_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : sub_32_pipe
//  Description : Pipelined subtractor Rslt = In_A - In_B (mod 2^WIDTH).
//                Each stage resolves one SEG_W-bit segment and forwards its
//                carry to the next; operands and finished low segments ride
//                along in skew registers. Whole-pipe stall via valid/ready.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                In_A, In_B          - minuend / subtrahend
//                in_valid, in_ready  - input handshake
//                Rslt                - difference
//                borrow              - unsigned underflow (In_A < In_B)
//                ovf                 - signed overflow
//                out_valid, out_ready- output handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module sub_32_pipe
    import sub_32_pkg::*;
#(
    parameter int WIDTH = c_DEF_WIDTH,
    parameter int SEG_W = c_DEF_SEG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] In_A,
    input  logic [WIDTH-1:0] In_B,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Rslt,
    output logic             borrow,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int c_NSEG = nseg_of(WIDTH, SEG_W);

    if (!seg_cfg_ok(WIDTH, SEG_W)) begin : g_cfg_check
        $error("sub_32_pipe: WIDTH must be a non-zero multiple of SEG_W");
    end

    // Stage k registers: valid bit, full operands (skew), finished low result
    // segments 0..k-1. The segment adders hold the stage-k difference/carry.
    logic [c_NSEG-1:0] r_vld;
    logic [WIDTH-1:0]  r_a   [c_NSEG];
    logic [WIDTH-1:0]  r_b   [c_NSEG];
    logic [WIDTH-1:0]  r_res [c_NSEG];
    logic [SEG_W-1:0]  w_diff[c_NSEG];
    logic [c_NSEG-1:0] w_cout;
    logic              w_adv;
    logic [WIDTH-1:0]  w_rslt;

    // Whole-pipe advance: only a stalled, valid output blocks the pipe.
    assign w_adv    = !r_vld[c_NSEG-1] || out_ready;
    assign in_ready = w_adv;

    for (genvar k = 0; k < c_NSEG; k++) begin : g_seg
        logic [SEG_W-1:0] w_a_seg;
        logic [SEG_W-1:0] w_b_seg;
        logic             w_cin;

        if (k == 0) begin : g_first
            assign w_a_seg = In_A[SEG_W-1:0];
            assign w_b_seg = In_B[SEG_W-1:0];
            assign w_cin   = 1'b1;          // +1 of the two's-complement negate
        end else begin : g_rest
            assign w_a_seg = r_a[k-1][k*SEG_W +: SEG_W];
            assign w_b_seg = r_b[k-1][k*SEG_W +: SEG_W];
            assign w_cin   = w_cout[k-1];
        end

        sub_seg #(
            .SEG_W (SEG_W)
        ) u_seg (
            .clk    (clk),
            .rst    (rst),
            .i_en   (w_adv),
            .i_a    (w_a_seg),
            .i_b    (w_b_seg),
            .i_cin  (w_cin),
            .o_diff (w_diff[k]),
            .o_cout (w_cout[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            for (int k = 0; k < c_NSEG; k++) begin
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_res[k] <= '0;
            end
        end else if (w_adv) begin
            r_vld[0] <= in_valid;
            r_a[0]   <= In_A;
            r_b[0]   <= In_B;
            r_res[0] <= '0;
            for (int k = 1; k < c_NSEG; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_a[k]   <= r_a[k-1];
                r_b[k]   <= r_b[k-1];
                r_res[k] <= r_res[k-1];
                r_res[k][(k-1)*SEG_W +: SEG_W] <= w_diff[k-1];
            end
        end
    end

    // Final stage: low segments from skew, top segment from the last adder.
    always_comb begin
        w_rslt                       = r_res[c_NSEG-1];
        w_rslt[WIDTH-1 -: SEG_W]     = w_diff[c_NSEG-1];
    end

    assign Rslt      = w_rslt;
    assign borrow    = !w_cout[c_NSEG-1];
    // Operands of differing sign, and result sign differs from the minuend.
    assign ovf       = (r_a[c_NSEG-1][WIDTH-1] ^ r_b[c_NSEG-1][WIDTH-1]) &
                       (r_a[c_NSEG-1][WIDTH-1] ^ w_rslt[WIDTH-1]);
    assign out_valid = r_vld[c_NSEG-1];

endmodule
`default_nettype wire

// File: tb/tb_sub_32_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sub_32_pipe
//  Description : Self-checking bench for sub_32_pipe. A queue-based reference
//                model computes each expected difference and flags with plain
//                integer arithmetic; directed cases, backpressured streaming,
//                mid-stream reset and a randomized phase are scored against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sub_32_pipe;

    localparam int c_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] In_A;
    logic [31:0] In_B;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Rslt;
    logic        borrow;
    logic        ovf;
    logic        out_valid;
    logic        out_ready;

    always #5 clk = ~clk;

    sub_32_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .In_A      (In_A),
        .In_B      (In_B),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Rslt      (Rslt),
        .borrow    (borrow),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic [31:0] r;
        logic        b;
        logic        o;
        int          cyc;
        bit          exact;
    } exp_t;

    exp_t        q[$];
    logic [31:0] popq[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          n_pop = 0;
    bit          rst_applied  = 0;
    bit          hold_pending = 0;
    bit          g_exact      = 0;
    bit          last_in_xfer = 0;
    logic [31:0] last_r;
    logic        last_b;
    logic        last_o;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      ua, ub, sa, sb, sd;
        logic [63:0] t;
        ua = longint'(a);
        ub = longint'(b);
        t  = ua - ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sd = sa - sb;
        e.r = t[31:0];
        e.b = (ua < ub);
        e.o = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        e.cyc = 0;
        e.exact = 0;
        return e;
    endfunction

    task automatic tick();
        exp_t e;
        last_in_xfer = 0;
        @(negedge clk);
        if (rst_applied) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_rslt", Rslt, 0);
            chk("rst_borrow", borrow, 0);
            chk("rst_ovf", ovf, 0);
        end
        if (rst) begin
            q.delete();
            hold_pending = 0;
        end else begin
            chk("in_ready", in_ready, !(out_valid && !out_ready));
            if (hold_pending) chk("stall_hold_valid", out_valid, 1);
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", out_valid, 0);
                end else begin
                    chk("rslt", Rslt, q[0].r);
                    chk("borrow", borrow, q[0].b);
                    chk("ovf", ovf, q[0].o);
                    if (out_ready) begin
                        e = q.pop_front();
                        if (e.exact) chk("latency", cyc - e.cyc, c_LAT);
                        last_r = Rslt;
                        last_b = borrow;
                        last_o = ovf;
                        popq.push_back(Rslt);
                        n_pop++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                e = model(In_A, In_B);
                e.cyc = cyc;
                e.exact = g_exact;
                q.push_back(e);
                last_in_xfer = 1;
            end
            hold_pending = out_valid && !out_ready;
        end
        @(posedge clk);
        rst_applied = rst;
        #1;
        cyc++;
    endtask

    task automatic drain(input string tag, input int maxc);
        int n;
        n = 0;
        in_valid  = 0;
        out_ready = 1;
        while (q.size() > 0 && n < maxc) begin
            tick();
            n++;
        end
        chk(tag, q.size(), 0);
    endtask

    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] er, input logic eb, input logic eo);
        int pops;
        pops      = n_pop;
        g_exact   = 1;
        In_A      = a;
        In_B      = b;
        in_valid  = 1;
        out_ready = 1;
        tick();
        in_valid  = 0;
        for (int i = 0; i < c_LAT + 2; i++) tick();
        g_exact   = 0;
        chk({tag, "_count"}, n_pop - pops, 1);
        chk({tag, "_rslt"}, last_r, er);
        chk({tag, "_borrow"}, last_b, eb);
        chk({tag, "_ovf"}, last_o, eo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return {16'h0000, 16'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "bench timeout");
    end

    initial begin
        int sent, k, base;

        // Reset held with valid input present.
        rst = 1; in_valid = 1; out_ready = 1;
        In_A = 32'h1234_5678; In_B = 32'h0000_0001;
        for (int i = 0; i < 4; i++) tick();
        rst = 0; in_valid = 0;
        tick();

        // Directed boundary cases.
        directed("seg_borrow", 32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 0, 0);
        directed("wrap",       32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1, 0);
        directed("sovf",       32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 0, 1);

        // Back-to-back stream under a periodic backpressure pattern.
        base = popq.size();
        sent = 0;
        k    = 0;
        while (sent < 8 && k < 100) begin
            In_A      = (sent + 1) * 32'h0001_0001;
            In_B      = sent + 1;
            in_valid  = 1;
            out_ready = (k % 3 == 0);
            tick();
            if (last_in_xfer) sent++;
            k++;
        end
        chk("stream_sent", sent, 8);
        drain("stream_drain", 60);
        chk("stream_count", popq.size() - base, 8);
        for (int i = 0; i < 8 && base + i < popq.size(); i++)
            chk("stream_order", popq[base + i], (i + 1) * 32'h0001_0000);

        // Reset with two items in flight: neither may emerge.
        base = n_pop;
        out_ready = 0; in_valid = 1;
        In_A = 32'h0000_0011; In_B = 32'h0000_0001;
        tick();
        chk("mid_xfer1", last_in_xfer, 1);
        In_A = 32'h0000_0022; In_B = 32'h0000_0002;
        tick();
        chk("mid_xfer2", last_in_xfer, 1);
        in_valid = 0; rst = 1;
        tick();
        rst = 0; out_ready = 1;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_flushed", n_pop - base, 0);
        directed("after_rst", 32'd5, 32'd3, 32'd2, 0, 0);

        // Randomized traffic with random bubbles and backpressure.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            In_A      = pick();
            In_B      = pick();
            tick();
        end
        drain("final_drain", 60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
